clk_enable_synth: RTL and testbench
===================================

Name: clk_enable_synth

Overview:
- Multi-channel fractional clock-enable synthesiser on a single reference clock; one phase accumulator per channel.
- Produces one-cycle clock-enable pulses at programmable average rates: f_ce = f_refclk * incr / 2^ACC_WIDTH.
- Runtime retuning uses a valid/ready config port; a lock indicator mirrors a PLL's locked output.
- Sits downstream of the board PLL and feeds the processor, memory-cycle and video timing logic, so further analogue PLL outputs are not needed.

Parameters:
- NUM_CHANNELS, 2, number of independent enable outputs (1..16).
- ACC_WIDTH, 32, phase accumulator width in bits (8..48).
- LOCK_CYCLES, 1024, settle period in refclk cycles before locked asserts (>=2).
- DEFAULT_INCR, 0, increment loaded into every channel at reset.

Ports:
- refclk  input  1  sole clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  block can accept a config request.
- cfg_channel  input  4  target channel index.
- cfg_incr  input  ACC_WIDTH  new phase increment.
- cfg_err  output  1  one-cycle pulse: request accepted with an out-of-range channel.
- ce  output  NUM_CHANNELS  per-channel one-cycle clock-enable pulses.
- locked  output  1  high while outputs are valid and stable.

Behaviour:
- Reset (rst sampled high): all accumulators = 0; all incr registers = DEFAULT_INCR; ce = 0; locked = 0; cfg_ready = 0; cfg_err = 0; settle counter = 0; state = SETTLE. rst mid-settle or mid-handshake discards everything and restarts from this state.
- Accumulator, every cycle not in reset: {carry, acc} = acc + incr (ACC_WIDTH+1-bit sum). acc takes the low ACC_WIDTH bits, so it wraps modulo 2^ACC_WIDTH.
- ce output: ce[i] is registered as carry[i] & (state == LOCKED). This adds one cycle of latency from carry to pulse. A channel with incr = 0 never pulses. incr = 2^ACC_WIDTH-1 pulses on all but 1 of every 2^ACC_WIDTH cycles.
- FSM, two states:
  - SETTLE: the counter increments every cycle. When counter == LOCK_CYCLES-1, go to LOCKED. locked first reads 1 on the LOCK_CYCLES-th rising edge after rst is released. Accumulators keep running; ce is held at 0.
  - LOCKED: locked = 1, cfg_ready = 1.
- Handshake: a request is accepted on an edge where cfg_valid & cfg_ready. cfg_ready is a registered state decode, not combinational from cfg_valid. cfg_ready is 0 throughout SETTLE, so requests stall, and the master must hold cfg_valid and its payload stable until accepted.
- Valid accept (cfg_channel < NUM_CHANNELS), all on the accept edge:
  - incr[cfg_channel] <= cfg_incr.
  - acc[cfg_channel] <= 0.
  - Counter <= 0; state <= SETTLE.
  - Effect: locked and cfg_ready read 0 from the next cycle, and no ce pulse on any channel appears from the next cycle until lock returns (LOCK_CYCLES cycles later). Untouched channels keep their accumulator phase.
- Invalid accept (cfg_channel >= NUM_CHANNELS): no register changes; state stays LOCKED; cfg_err = 1 for exactly the next cycle.
- Simultaneous carry and accept edge: a ce pulse registered on the accept edge from the old state is still output in the next cycle. From the cycle after that, gating applies.

Test Plan:
- ACC_WIDTH=8, LOCK_CYCLES=16, DEFAULT_INCR=64, NUM_CHANNELS=2; release rst -> locked first high 16 edges after release; ce[0] and ce[1] then pulse exactly every 4 cycles, in phase, each 1 cycle wide.
- While locked, write ch1 incr=128 -> cfg_ready and locked drop the next cycle; no ce for 16 cycles; then ce[1] every 2 cycles and ce[0] every 4 cycles, with ce[0] phase unchanged vs. pre-write.
- Write ch0 incr=0 -> after relock, ce[0] stays 0 for 1000 cycles; write incr=255 -> ce[0] is high 255 of every 256 cycles.
- Write cfg_channel=5 -> cfg_err pulses 1 cycle; locked stays 1; both ce streams are unaffected.
- Hold cfg_valid during SETTLE -> not accepted until cfg_ready=1, then accepted exactly once.
- Assert rst for 1 cycle mid-settle and mid-locked -> all outputs 0, incr restored to 64, relock 16 cycles after release.

Source files
------------

// File: rtl/clk_enable_synth.sv
// Multi-channel fractional clock-enable synthesiser.
// Each channel owns a phase accumulator; its carry-out becomes a one-cycle
// enable pulse, giving an average rate of f_refclk * incr / 2^ACC_WIDTH.
// A settle/lock FSM gates all pulses after reset and after every retune so
// downstream logic only ever sees enables from a stable configuration.

// Per-channel phase accumulator with a loadable increment.
module clk_enable_synth_ch #(
    parameter int              ACC_WIDTH    = 32,
    parameter longint unsigned DEFAULT_INCR = 0
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [ACC_WIDTH-1:0] i_incr,
    output logic                 o_carry
);
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_incr;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_incr};
    assign o_carry = w_sum[ACC_WIDTH];

    // Free-running accumulate; a retune restarts the phase from zero.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_acc  <= '0;
            r_incr <= ACC_WIDTH'(DEFAULT_INCR);
        end else if (i_wr) begin
            r_acc  <= '0;
            r_incr <= i_incr;
        end else begin
            r_acc  <= w_sum[ACC_WIDTH-1:0];
        end
    end
endmodule

// Top: channel array, settle/lock FSM, config handshake and ce gating.
module clk_enable_synth #(
    parameter int              NUM_CHANNELS = 2,
    parameter int              ACC_WIDTH    = 32,
    parameter int              LOCK_CYCLES  = 1024,
    parameter longint unsigned DEFAULT_INCR = 0
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [3:0]              cfg_channel,
    input  logic [ACC_WIDTH-1:0]    cfg_incr,
    output logic                    cfg_err,
    output logic [NUM_CHANNELS-1:0] ce,
    output logic                    locked
);
    localparam int CNT_W = $clog2(LOCK_CYCLES);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [NUM_CHANNELS-1:0] r_ce;
    logic                    r_cfg_err;
    logic [NUM_CHANNELS-1:0] w_carry;
    logic [NUM_CHANNELS-1:0] w_wr;
    logic                    w_is_locked;
    logic                    w_accept;
    logic                    w_ch_ok;
    logic                    w_wr_ok;

    // Ready and locked are pure decodes of the state register, so the
    // handshake never depends combinationally on cfg_valid.
    assign w_is_locked = (r_state == ST_LOCKED);
    assign cfg_ready   = w_is_locked;
    assign locked      = w_is_locked;
    assign ce          = r_ce;
    assign cfg_err     = r_cfg_err;

    assign w_accept = cfg_valid & cfg_ready;
    assign w_ch_ok  = ({1'b0, cfg_channel} < 5'(NUM_CHANNELS));
    assign w_wr_ok  = w_accept & w_ch_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            assign w_wr[gi] = w_wr_ok & (cfg_channel == 4'(gi));

            clk_enable_synth_ch #(
                .ACC_WIDTH    (ACC_WIDTH),
                .DEFAULT_INCR (DEFAULT_INCR)
            ) u_ch (
                .refclk  (refclk),
                .rst     (rst),
                .i_wr    (w_wr[gi]),
                .i_incr  (cfg_incr),
                .o_carry (w_carry[gi])
            );
        end
    endgenerate

    // Next-state: count out the settle period, drop back to settle on retune.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_SETTLE: begin
                if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    w_state_nxt = ST_LOCKED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_wr_ok) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SETTLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and settle counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Gate carries with the current state: a carry on the accept edge still
    // gets out, everything after it is held off until relock.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_ce      <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_ce      <= w_carry & {NUM_CHANNELS{w_is_locked}};
            r_cfg_err <= w_accept & ~w_ch_ok;
        end
    end
endmodule

// File: tb/tb_clk_enable_synth.sv
// Directed bench for clk_enable_synth: 2 channels, 8-bit accumulators,
// 16-cycle settle, default increment 64. Edge numbers in comments count
// rising edges after the first reset release.
module tb_clk_enable_synth;
    localparam int NC = 2;
    localparam int AW = 8;
    localparam int LC = 16;
    localparam int DI = 64;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [3:0]    cfg_channel = '0;
    logic [AW-1:0] cfg_incr = '0;
    logic          cfg_ready;
    logic          cfg_err;
    logic          locked;
    logic [NC-1:0] ce;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int c0;
    int c1;

    always #5 refclk = ~refclk;

    clk_enable_synth #(
        .NUM_CHANNELS (NC),
        .ACC_WIDTH    (AW),
        .LOCK_CYCLES  (LC),
        .DEFAULT_INCR (DI)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_channel (cfg_channel),
        .cfg_incr    (cfg_incr),
        .cfg_err     (cfg_err),
        .ce          (ce),
        .locked      (locked)
    );

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_ce", 32'(ce), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_ready", 32'(cfg_ready), 0);
        chk("rst_err", 32'(cfg_err), 0);
        rst = 1'b0;

        // settle: edges 1..15 unlocked, lock on edge 16
        for (int k = 1; k <= LC - 1; k++) begin
            tick();
            chk("settle_locked", 32'(locked), 0);
            chk("settle_ce", 32'(ce), 0);
        end
        tick();
        chk("lock_edge16", 32'(locked), 1);
        chk("ready_edge16", 32'(cfg_ready), 1);
        chk("ce_edge16", 32'(ce), 0);

        // both channels every 4 edges, in phase (edges 20, 24, ...)
        for (int n = 17; n <= 32; n++) begin
            tick();
            chk("ce_init", 32'(ce), (n % 4 == 0) ? 3 : 0);
        end

        // retune ch1 to 128, accepted on edge 33
        cfg_valid = 1'b1; cfg_channel = 4'd1; cfg_incr = 8'd128;
        tick();
        cfg_valid = 1'b0;
        chk("wr1_locked", 32'(locked), 0);
        chk("wr1_ready", 32'(cfg_ready), 0);
        chk("wr1_ce", 32'(ce), 0);
        for (int n = 34; n <= 48; n++) begin
            tick();
            chk("wr1_settle_ce", 32'(ce), 0);
            chk("wr1_settle_locked", 32'(locked), 0);
        end
        tick();
        chk("wr1_relock", 32'(locked), 1);
        // ch0 keeps its phase (multiples of 4), ch1 now on odd edges
        for (int n = 50; n <= 67; n++) begin
            tick();
            chk("ce_after_wr1", 32'(ce), ((n % 2 == 1) ? 2 : 0) | ((n % 4 == 0) ? 1 : 0));
        end

        // ch0 incr=0 accepted on edge 68, same edge as a ch0 carry
        cfg_valid = 1'b1; cfg_channel = 4'd0; cfg_incr = 8'd0;
        tick();
        cfg_valid = 1'b0;
        chk("carry_on_accept", 32'(ce), 1);
        chk("wr0_locked", 32'(locked), 0);
        tick();
        chk("gated_after_accept", 32'(ce), 0);
        for (int n = 70; n <= 83; n++) tick();
        chk("wr0_pre_lock", 32'(locked), 0);
        tick();
        chk("wr0_relock", 32'(locked), 1);
        c0 = 0; c1 = 0;
        for (int n = 85; n <= 1084; n++) begin
            tick();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        chk("incr0_no_pulse", 32'(c0), 0);
        chk("incr0_ch1_count", 32'(c1), 500);

        // ch0 incr=255 accepted on edge 1085 (ch1 carry on same edge)
        cfg_valid = 1'b1; cfg_channel = 4'd0; cfg_incr = 8'd255;
        tick();
        cfg_valid = 1'b0;
        chk("ce1_on_accept", 32'(ce), 2);
        for (int n = 1086; n <= 1100; n++) tick();
        tick();
        chk("ff_relock", 32'(locked), 1);
        c0 = 0; c1 = 0;
        for (int n = 1102; n <= 1357; n++) begin
            tick();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
            if (n == 1342) chk("ff_gap", 32'(ce[0]), 0);
        end
        chk("ff_count", 32'(c0), 255);
        chk("ff_ch1_count", 32'(c1), 128);

        // out-of-range channel on edge 1358
        cfg_valid = 1'b1; cfg_channel = 4'd5; cfg_incr = 8'd99;
        tick();
        cfg_valid = 1'b0;
        chk("err_pulse", 32'(cfg_err), 1);
        chk("err_locked", 32'(locked), 1);
        chk("err_ready", 32'(cfg_ready), 1);
        chk("err_ce", 32'(ce), 1);
        tick();
        chk("err_clear", 32'(cfg_err), 0);
        chk("err_ce_next", 32'(ce), 3);

        // ch1=64 accepted on edge 1360, then ch0=128 held through settle
        cfg_valid = 1'b1; cfg_channel = 4'd1; cfg_incr = 8'd64;
        tick();
        cfg_channel = 4'd0; cfg_incr = 8'd128;
        chk("hold_first_acc", 32'(locked), 0);
        for (int n = 1361; n <= 1375; n++) begin
            tick();
            chk("hold_stall_ready", 32'(cfg_ready), 0);
        end
        tick();
        chk("hold_ready", 32'(cfg_ready), 1);
        chk("hold_locked", 32'(locked), 1);
        tick();
        cfg_valid = 1'b0;
        chk("hold_accepted", 32'(locked), 0);
        chk("hold_accepted_rdy", 32'(cfg_ready), 0);
        for (int n = 1378; n <= 1392; n++) tick();
        chk("hold_pre_lock", 32'(locked), 0);
        tick();
        chk("hold_relock", 32'(locked), 1);
        for (int n = 1394; n <= 1401; n++) begin
            tick();
            chk("hold_ce", 32'(ce), ((n % 2 == 1) ? 1 : 0) | (((n - 1360) % 4 == 0) ? 2 : 0));
        end

        // reset while locked
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstl_ce", 32'(ce), 0);
        chk("rstl_locked", 32'(locked), 0);
        chk("rstl_ready", 32'(cfg_ready), 0);
        chk("rstl_err", 32'(cfg_err), 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rstl_settle", 32'(locked), 0);
        end

        // reset mid-settle, then full relock with default increments
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsts_locked", 32'(locked), 0);
        chk("rsts_ce", 32'(ce), 0);
        for (int k = 1; k <= LC - 1; k++) begin
            tick();
            chk("rsts_settle", 32'(locked), 0);
        end
        tick();
        chk("rsts_relock", 32'(locked), 1);
        for (int n = 1428; n <= 1435; n++) begin
            tick();
            chk("rsts_ce_default", 32'(ce), ((n - 1411) % 4 == 0) ? 3 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
